// File: rtl/btn_conditioner.sv
// ============================================================================
// Module  : btn_conditioner
// Brief   : N-channel button front end: 2-FF sync, debounce, edge pulses and
//           optional hold-to-repeat (enabled by macro BTN_AUTOREPEAT_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_conditioner #(
  parameter int N_BTN      = 3,
  parameter int DB_CYCLES  = 1_000_000,
  parameter int RPT_DELAY  = 40_000_000,
  parameter int RPT_PERIOD = 10_000_000
) (
  input  logic             clk_100m,
  input  logic             btn_rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press,
  output logic [7:0]       debug
);

  localparam int CW = $clog2(DB_CYCLES);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_DELAY  = 2'b01;
  localparam logic [1:0] ST_REPEAT = 2'b10;

  logic [1:0] state0;
  logic [5:0] lvl6;

  genvar i;
  generate
    for (i = 0; i < N_BTN; i++) begin : g_ch
      logic          sync1;
      logic          sync2;
      logic          level;
      logic          rel_q;
      logic          press_q;
      logic [CW-1:0] cnt;
      logic          db_done;
      logic          rise;
      logic          fall;

      // Level flips on the edge where the counter saturates; edges are derived
      // from that same condition so pulses line up with the new level.
      assign db_done = (sync2 != level) && (cnt == CW'(DB_CYCLES - 1));
      assign rise    = db_done && sync2;
      assign fall    = db_done && !sync2;

      always_ff @(posedge clk_100m or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
          sync1 <= 1'b0;
          sync2 <= 1'b0;
          level <= 1'b0;
          cnt   <= '0;
          rel_q <= 1'b0;
        end else begin
          sync1 <= btn_raw[i];
          sync2 <= sync1;
          if (sync2 == level) begin
            cnt <= '0;
          end else if (cnt == CW'(DB_CYCLES - 1)) begin
            level <= sync2;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
          rel_q <= fall;
        end
      end

`ifdef BTN_AUTOREPEAT_EN
      localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
      localparam int TW      = $clog2(RPT_MAX);

      logic [1:0]    state;
      logic [1:0]    state_nxt;
      logic [TW-1:0] timer;
      logic [TW-1:0] timer_nxt;
      logic          press_nxt;
      logic          gone;

      // A fall reported this cycle counts as released, so it beats a timer expiry.
      assign gone = fall || !level;

      always_ff @(posedge clk_100m or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
          state   <= ST_IDLE;
          timer   <= '0;
          press_q <= 1'b0;
        end else begin
          state   <= state_nxt;
          timer   <= timer_nxt;
          press_q <= press_nxt;
        end
      end

      always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
          ST_IDLE: begin
            if (rise) begin
              state_nxt = ST_DELAY;
              timer_nxt = '0;
            end
          end
          ST_DELAY: begin
            if (gone) begin
              state_nxt = ST_IDLE;
              timer_nxt = '0;
            end else if (timer == TW'(RPT_DELAY - 1)) begin
              state_nxt = ST_REPEAT;
              timer_nxt = '0;
            end else begin
              timer_nxt = timer + TW'(1);
            end
          end
          ST_REPEAT: begin
            if (gone) begin
              state_nxt = ST_IDLE;
              timer_nxt = '0;
            end else if (timer == TW'(RPT_PERIOD - 1)) begin
              timer_nxt = '0;
            end else begin
              timer_nxt = timer + TW'(1);
            end
          end
          default: begin
            state_nxt = ST_IDLE;
            timer_nxt = '0;
          end
        endcase
      end

      always_comb begin
        press_nxt = 1'b0;
        case (state)
          ST_IDLE:   press_nxt = rise;
          ST_DELAY:  press_nxt = !gone && (timer == TW'(RPT_DELAY - 1));
          ST_REPEAT: press_nxt = !gone && (timer == TW'(RPT_PERIOD - 1));
          default:   press_nxt = 1'b0;
        endcase
      end

      if (i == 0) begin : g_dbg
        assign state0 = state;
      end
`else
      always_ff @(posedge clk_100m or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
          press_q <= 1'b0;
        end else begin
          press_q <= rise;
        end
      end
`endif

      assign btn_level[i]   = level;
      assign btn_press[i]   = press_q;
      assign btn_release[i] = rel_q;
    end

    for (i = 0; i < 6; i++) begin : g_pad
      if (i < N_BTN) begin : g_bit
        assign lvl6[i] = btn_level[i];
      end else begin : g_zero
        assign lvl6[i] = 1'b0;
      end
    end
  endgenerate

`ifndef BTN_AUTOREPEAT_EN
  assign state0 = ST_IDLE;
`endif

  assign any_press = |btn_press;
  assign debug     = {state0, lvl6};

endmodule

`default_nettype wire

// File: tb/tb_btn_conditioner.sv
// ============================================================================
// Module  : tb_btn_conditioner
// Brief   : Directed vector table plus hand sequences for btn_conditioner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_conditioner;

  logic       clk_100m = 1'b0;
  logic       btn_rst_n;
  logic [2:0] btn_raw;
  logic [2:0] btn_level;
  logic [2:0] btn_press;
  logic [2:0] btn_release;
  logic       any_press;
  logic [7:0] debug;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  btn_conditioner #(
    .N_BTN     (3),
    .DB_CYCLES (4),
    .RPT_DELAY (20),
    .RPT_PERIOD(8)
  ) dut (
    .clk_100m   (clk_100m),
    .btn_rst_n  (btn_rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_press  (any_press),
    .debug      (debug)
  );

  always #5 clk_100m = ~clk_100m;

  typedef struct {
    logic [2:0] raw;
    logic [2:0] lvl;
    logic [2:0] prs;
    logic [2:0] rel;
    logic       any;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] raw);
    btn_raw = raw;
    @(posedge clk_100m);
    #1;
  endtask

  task automatic add(input logic [2:0] raw, input logic [2:0] lvl, input logic [2:0] prs,
                     input logic [2:0] rel, input logic any);
    vec_t v;
    v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel; v.any = any;
    tbl.push_back(v);
  endtask

  function automatic logic [1:0] exp_state(input int rel, input int fall_at);
    if (!EN || rel < 0 || rel >= fall_at) return 2'b00;
    if (rel < 20) return 2'b01;
    return 2'b10;
  endfunction

  initial begin
    logic       exp_p;
    logic       exp_l;
    logic [1:0] st;
    int         rel;

    // Clean press on channel 1, then a simultaneous press on channels 0 and 1.
    for (int r = 0; r < 4; r++) add(3'b010, 3'b000, 3'b000, 3'b000, 1'b0);
    add(3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    add(3'b000, 3'b010, 3'b010, 3'b000, 1'b1);
    for (int r = 0; r < 3; r++) add(3'b000, 3'b010, 3'b000, 3'b000, 1'b0);
    add(3'b000, 3'b000, 3'b000, 3'b010, 1'b0);
    add(3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    add(3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    for (int r = 0; r < 5; r++) add(3'b011, 3'b000, 3'b000, 3'b000, 1'b0);
    add(3'b011, 3'b011, 3'b011, 3'b000, 1'b1);
    for (int r = 0; r < 5; r++) add(3'b000, 3'b011, 3'b000, 3'b000, 1'b0);
    add(3'b000, 3'b000, 3'b000, 3'b011, 1'b0);
    add(3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

    // Reset held with all buttons pressed.
    btn_rst_n = 1'b0;
    btn_raw   = 3'b111;
    for (int c = 0; c < 3; c++) begin
      step(3'b111);
      check("rst_level", 32'(btn_level), 32'(3'b000));
      check("rst_press", 32'({btn_press, btn_release, any_press}), 32'd0);
      check("rst_debug", 32'(debug), 32'd0);
    end
    btn_rst_n = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step(3'b111);
      if (c == 5) check("rstrel_c5", 32'({btn_level, btn_press}), 32'd0);
      if (c == 6) begin
        check("rstrel_lvl", 32'(btn_level), 32'(3'b111));
        check("rstrel_press", 32'({btn_press, any_press}), 32'({3'b111, 1'b1}));
        check("rstrel_debug", 32'(debug), 32'({EN ? 2'b01 : 2'b00, 6'b000111}));
      end
      if (c == 7) check("rstrel_c7", 32'({btn_level, btn_press}), 32'({3'b111, 3'b000}));
    end
    for (int c = 1; c <= 8; c++) begin
      step(3'b000);
      if (c == 6) check("rstrel_fall", 32'({btn_level, btn_release}), 32'({3'b000, 3'b111}));
    end
    check("rstrel_idle", 32'({btn_level, btn_press, btn_release}), 32'd0);

    // Bounce on channel 0: 3-cycle phases never satisfy the 4-cycle debounce.
    for (int c = 0; c < 16; c++) begin
      step(((c / 3) % 2 == 0 && c < 12) ? 3'b001 : 3'b000);
      check("bounce", 32'({btn_level[0], btn_press[0], btn_release[0]}), 32'd0);
    end

    // Table-driven clean and simultaneous presses.
    for (int r = 0; r < tbl.size(); r++) begin
      step(tbl[r].raw);
      check($sformatf("tbl%0d_lvl", r), 32'(btn_level), 32'(tbl[r].lvl));
      check($sformatf("tbl%0d_prs", r), 32'(btn_press), 32'(tbl[r].prs));
      check($sformatf("tbl%0d_rel", r), 32'(btn_release), 32'(tbl[r].rel));
      check($sformatf("tbl%0d_any", r), 32'(any_press), 32'(tbl[r].any));
    end

    // Hold-to-repeat on channel 2: level high for 50 cycles.
    for (int c = 0; c < 62; c++) begin
      step(c < 50 ? 3'b100 : 3'b000);
      rel   = c - 5;
      exp_l = (rel >= 0 && rel <= 49);
      exp_p = EN ? (rel == 0 || rel == 20 || rel == 28 || rel == 36 || rel == 44) : (rel == 0);
      check($sformatf("rpt%0d", rel), 32'({btn_level[2], btn_press[2], btn_release[2]}),
            32'({exp_l, exp_p, rel == 50}));
    end

    // Collision on channel 0: fall coincides with the second repeat expiry.
    for (int c = 0; c < 40; c++) begin
      step(c < 28 ? 3'b001 : 3'b000);
      rel   = c - 5;
      exp_l = (rel >= 0 && rel <= 27);
      exp_p = EN ? (rel == 0 || rel == 20) : (rel == 0);
      st    = exp_state(rel, 28);
      check($sformatf("col%0d", rel), 32'({btn_level[0], btn_press[0], btn_release[0]}),
            32'({exp_l, exp_p, rel == 28}));
      check($sformatf("col%0d_dbg", rel), 32'(debug), 32'({st, 5'b00000, exp_l}));
    end

    // Asynchronous reset while channel 0 is held, then fresh press after release.
    for (int c = 0; c < 8; c++) step(3'b001);
    check("mid_pre", 32'(btn_level), 32'(3'b001));
    #2 btn_rst_n = 1'b0;
    #1;
    check("mid_async", 32'({btn_level, btn_press, btn_release, any_press, debug}), 32'd0);
    step(3'b001);
    step(3'b001);
    btn_rst_n = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step(3'b001);
      if (c <= 5) check($sformatf("mid_c%0d", c), 32'({btn_level, btn_press, btn_release}), 32'd0);
      if (c == 6) check("mid_c6", 32'({btn_level, btn_press, any_press}), 32'({3'b001, 3'b001, 1'b1}));
      if (c == 7) check("mid_c7", 32'({btn_level, btn_press}), 32'({3'b001, 3'b000}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
